// File: rtl/edge_event_pkg.sv
// Shared types and default sizing for the multi-channel edge event detector.
package edge_event_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_W      = 4;

endpackage

// File: rtl/edge_event_channel.sv
// One input channel: synchroniser, glitch filter, filtered level, edge pulse and sticky flag.
module edge_event_channel
  import edge_event_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_W      = DEF_FILT_W
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              data_i,
  input  logic [1:0]        mode_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              clr_i,
  output logic              pulse_o,
  output logic              flag_o,
  output logic              level_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   flag_q, flag_d;
  logic                   qualify;

  // Direction of the pending toggle is the opposite of the current level.
  always_comb begin
    case (edge_mode_t'(mode_i))
      EDGE_RISE: qualify = ~level_q;
      EDGE_FALL: qualify = level_q;
      EDGE_BOTH: qualify = 1'b1;
      default:   qualify = 1'b0;
    endcase
  end

  always_comb begin
    sync_d  = sync_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (ena) begin
      sync_d = {sync_q[SYNC_STAGES-2:0], data_i};
      if (sync_q[SYNC_STAGES-1] == level_q) begin
        cnt_d = '0;
      end else if (cnt_q < filt_len_i) begin
        cnt_d = cnt_q + FILT_W'(1);
      end else begin
        cnt_d   = '0;
        level_d = ~level_q;
        pulse_d = qualify;
      end
    end
    // Flag is set from the registered pulse so a clr seen alongside it cannot win.
    flag_d = pulse_q | (flag_q & ~clr_i);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
    end
  end

  assign pulse_o = pulse_q;
  assign flag_o  = flag_q;
  assign level_o = level_q;

endmodule

// File: rtl/edge_event_detector.sv
// Multi-channel edge event detector: per-channel instances plus the combined interrupt.
module edge_event_detector
  import edge_event_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_W      = DEF_FILT_W
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic [CHANNELS-1:0]   data,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [FILT_W-1:0]     filt_len,
  input  logic [CHANNELS-1:0]   clr,
  output logic [CHANNELS-1:0]   edge_pulse,
  output logic [CHANNELS-1:0]   edge_flag,
  output logic [CHANNELS-1:0]   level,
  output logic                  irq
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_event_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_W     (FILT_W)
    ) u_ch (
      .clk       (clk),
      .rstb      (rstb),
      .ena       (ena),
      .data_i    (data[i]),
      .mode_i    (mode[2*i +: 2]),
      .filt_len_i(filt_len),
      .clr_i     (clr[i]),
      .pulse_o   (edge_pulse[i]),
      .flag_o    (edge_flag[i]),
      .level_o   (level[i])
    );
  end

  assign irq = |edge_flag;

endmodule
